sys_ctrl_burst: RTL



---
 rtl/sys_ctrl_pkg.sv | 51 +++++
 rtl/sys_ctrl_tx_serializer.sv | 55 +++++
 rtl/sys_ctrl_burst.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the burst-capable UART command controller:
// opcode bytes, FSM state encoding, command kinds and small helpers.
package sys_ctrl_pkg;

  localparam logic [7:0] OP_WR      = 8'hAA;
  localparam logic [7:0] OP_RD      = 8'hBB;
  localparam logic [7:0] OP_ALU     = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;
  localparam logic [7:0] OP_BWR     = 8'hAE;
  localparam logic [7:0] OP_BRD     = 8'hBE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_CNT,
    ST_GET_DATA,
    ST_RF_WRITE,
    ST_RF_REQ,
    ST_RF_WAIT,
    ST_RF_SEND,
    ST_GET_OPA,
    ST_GET_OPB,
    ST_GET_FUNC,
    ST_ALU_RUN,
    ST_ALU_SEND
  } state_t;

  // Command kind remembered after the opcode byte; ALU variants share one
  // kind because they converge once the function byte is being awaited.
  typedef enum logic [2:0] {
    CMD_WR,
    CMD_RD,
    CMD_BWR,
    CMD_BRD,
    CMD_ALU
  } cmd_t;

  // Width of the result-byte index; at least one bit so a single-byte
  // result still has a legal counter.
  function automatic int idx_width(input int bytes);
    return (bytes <= 1) ? 1 : $clog2(bytes);
  endfunction

  // States that wait on an RX frame and are therefore covered by the
  // inter-frame timeout.
  function automatic logic is_get_state(input state_t s);
    return (s == ST_GET_ADDR) || (s == ST_GET_CNT) || (s == ST_GET_DATA) ||
           (s == ST_GET_OPA)  || (s == ST_GET_OPB) || (s == ST_GET_FUNC);
  endfunction

endpackage

// File: rtl/sys_ctrl_tx_serializer.sv
// Byte serializer feeding the TX FIFO. A start strobe loads a word and the
// index of its last byte; bytes then leave LSB first, one per cycle, only
// when the FIFO is not full. TX_DATA holds steady while stalled.
module sys_ctrl_tx_serializer
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_BYTES = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [RESULT_BYTES*DATA_WIDTH-1:0]     word,
  input  logic [idx_width(RESULT_BYTES)-1:0]     last_idx,
  input  logic                                   tx_full,
  output logic [DATA_WIDTH-1:0]                  tx_data,
  output logic                                   tx_wr,
  output logic                                   done
);

  localparam int IW = idx_width(RESULT_BYTES);

  logic [RESULT_BYTES*DATA_WIDTH-1:0] word_q;
  logic [IW-1:0]                      idx_q;
  logic [IW-1:0]                      last_q;
  logic                               active_q;
  logic                               accept;

  assign accept  = active_q && !tx_full;
  assign tx_wr   = accept;
  assign done    = accept && (idx_q == last_q);
  assign tx_data = active_q ? word_q[DATA_WIDTH-1:0] : '0;

  // Load on start, then shift one byte out per accepted FIFO write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      word_q   <= word;
      idx_q    <= '0;
      last_q   <= last_idx;
      active_q <= 1'b1;
    end else if (accept) begin
      word_q <= word_q >> DATA_WIDTH;
      idx_q  <= idx_q + IW'(1);
      if (idx_q == last_q) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sys_ctrl_burst.sv
// UART command controller with burst register access, multi-byte ALU
// results, TX back-pressure, inter-frame timeout and bad-command flag.
module sys_ctrl_burst
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_FUNC_WIDTH = 4,
  parameter int RESULT_BYTES   = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int OPA_ADDR       = 0,
  parameter int OPB_ADDR       = 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [DATA_WIDTH-1:0]              RX_DATA_IN,
  input  logic                               RX_DATA_VALID,
  output logic [ADDR_WIDTH-1:0]              RF_ADDR,
  output logic                               RF_WR_EN,
  output logic                               RF_RD_EN,
  output logic [DATA_WIDTH-1:0]              RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]              RF_RD_DATA,
  input  logic                               RF_RD_VALID,
  output logic [ALU_FUNC_WIDTH-1:0]          ALU_FUNC,
  output logic                               ALU_EN,
  output logic                               ALU_CLK_EN,
  input  logic [RESULT_BYTES*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                               ALU_OUT_VALID,
  output logic [DATA_WIDTH-1:0]              TX_DATA,
  output logic                               TX_WR,
  input  logic                               TX_FULL,
  output logic                               BUSY,
  output logic                               CMD_ERR
);

  localparam int RW = RESULT_BYTES * DATA_WIDTH;
  localparam int IW = idx_width(RESULT_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] CNT_ONE  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] C_WR     = DATA_WIDTH'(OP_WR);
  localparam logic [DATA_WIDTH-1:0] C_RD     = DATA_WIDTH'(OP_RD);
  localparam logic [DATA_WIDTH-1:0] C_ALU    = DATA_WIDTH'(OP_ALU);
  localparam logic [DATA_WIDTH-1:0] C_ALUNOP = DATA_WIDTH'(OP_ALU_NOP);
  localparam logic [DATA_WIDTH-1:0] C_BWR    = DATA_WIDTH'(OP_BWR);
  localparam logic [DATA_WIDTH-1:0] C_BRD    = DATA_WIDTH'(OP_BRD);

  state_t                    state, next_state;
  cmd_t                      cmd_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     cnt_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [ALU_FUNC_WIDTH-1:0] func_q;
  logic [TW-1:0]             tmo_q;
  logic                      op_wr_q;
  logic                      op_sel_q;
  logic                      err_q;

  logic                      err_set;
  logic                      tmo_hit;
  logic                      ser_start;
  logic [RW-1:0]             ser_word;
  logic [IW-1:0]             ser_last;
  logic                      ser_done;

  assign BUSY    = (state != ST_IDLE);
  assign CMD_ERR = err_q;

  // State register; reset abandons whatever command was in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the strobes and register-file/ALU outputs.
  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    ser_start  = 1'b0;
    ser_word   = '0;
    ser_last   = '0;
    RF_ADDR    = '0;
    RF_WR_EN   = 1'b0;
    RF_RD_EN   = 1'b0;
    RF_WR_DATA = '0;
    ALU_FUNC   = '0;
    ALU_EN     = 1'b0;
    ALU_CLK_EN = 1'b0;
    tmo_hit    = is_get_state(state) && !RX_DATA_VALID && (tmo_q == TMO_LAST);

    if (op_wr_q) begin
      RF_WR_EN   = 1'b1;
      RF_ADDR    = op_sel_q ? ADDR_WIDTH'(OPB_ADDR) : ADDR_WIDTH'(OPA_ADDR);
      RF_WR_DATA = data_q;
      ALU_CLK_EN = 1'b1;
    end

    unique case (state)
      ST_IDLE: begin
        if (RX_DATA_VALID) begin
          case (RX_DATA_IN)
            C_WR, C_RD, C_BWR, C_BRD: next_state = ST_GET_ADDR;
            C_ALU:                    next_state = ST_GET_OPA;
            C_ALUNOP:                 next_state = ST_GET_FUNC;
            default:                  err_set    = 1'b1;
          endcase
        end
      end
      ST_GET_ADDR: begin
        if (RX_DATA_VALID) begin
          if (cmd_q == CMD_WR) begin
            next_state = ST_GET_DATA;
          end else if (cmd_q == CMD_RD) begin
            next_state = ST_RF_REQ;
          end else begin
            next_state = ST_GET_CNT;
          end
        end
      end
      ST_GET_CNT: begin
        if (RX_DATA_VALID) begin
          if (RX_DATA_IN == '0) begin
            err_set    = 1'b1;
            next_state = ST_IDLE;
          end else if (cmd_q == CMD_BWR) begin
            next_state = ST_GET_DATA;
          end else begin
            next_state = ST_RF_REQ;
          end
        end
      end
      ST_GET_DATA: begin
        if (RX_DATA_VALID) begin
          next_state = ST_RF_WRITE;
        end
      end
      ST_RF_WRITE: begin
        RF_WR_EN   = 1'b1;
        RF_ADDR    = addr_q;
        RF_WR_DATA = data_q;
        next_state = (cnt_q == CNT_ONE) ? ST_IDLE : ST_GET_DATA;
      end
      ST_RF_REQ: begin
        RF_RD_EN   = 1'b1;
        RF_ADDR    = addr_q;
        next_state = ST_RF_WAIT;
      end
      ST_RF_WAIT: begin
        RF_ADDR = addr_q;
        if (RF_RD_VALID) begin
          ser_start                = 1'b1;
          ser_word[DATA_WIDTH-1:0] = RF_RD_DATA;
          next_state               = ST_RF_SEND;
        end
      end
      ST_RF_SEND: begin
        if (ser_done) begin
          next_state = (cnt_q == CNT_ONE) ? ST_IDLE : ST_RF_REQ;
        end
      end
      ST_GET_OPA: begin
        if (RX_DATA_VALID) begin
          next_state = ST_GET_OPB;
        end
      end
      ST_GET_OPB: begin
        if (RX_DATA_VALID) begin
          next_state = ST_GET_FUNC;
        end
      end
      ST_GET_FUNC: begin
        if (RX_DATA_VALID) begin
          next_state = ST_ALU_RUN;
        end
      end
      ST_ALU_RUN: begin
        ALU_FUNC   = func_q;
        ALU_EN     = 1'b1;
        ALU_CLK_EN = 1'b1;
        if (ALU_OUT_VALID) begin
          ser_start  = 1'b1;
          ser_word   = ALU_OUT;
          ser_last   = IW'(RESULT_BYTES - 1);
          next_state = ST_ALU_SEND;
        end
      end
      ST_ALU_SEND: begin
        if (ser_done) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase

    if (tmo_hit) begin
      err_set    = 1'b1;
      next_state = ST_IDLE;
    end
  end

  // Command datapath: captured fields, burst address/count stepping,
  // operand-write pending flag, timeout counter and the error pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmd_q    <= CMD_WR;
      addr_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      func_q   <= '0;
      tmo_q    <= '0;
      op_wr_q  <= 1'b0;
      op_sel_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q   <= err_set;
      op_wr_q <= 1'b0;
      if (RX_DATA_VALID || !is_get_state(state)) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (RX_DATA_VALID) begin
            cnt_q <= CNT_ONE;
            case (RX_DATA_IN)
              C_WR:            cmd_q <= CMD_WR;
              C_RD:            cmd_q <= CMD_RD;
              C_BWR:           cmd_q <= CMD_BWR;
              C_BRD:           cmd_q <= CMD_BRD;
              C_ALU, C_ALUNOP: cmd_q <= CMD_ALU;
              default:         cmd_q <= cmd_q;
            endcase
          end
        end
        ST_GET_ADDR: begin
          if (RX_DATA_VALID) addr_q <= RX_DATA_IN[ADDR_WIDTH-1:0];
        end
        ST_GET_CNT: begin
          if (RX_DATA_VALID) cnt_q <= RX_DATA_IN;
        end
        ST_GET_DATA: begin
          if (RX_DATA_VALID) data_q <= RX_DATA_IN;
        end
        ST_RF_WRITE: begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          cnt_q  <= cnt_q - CNT_ONE;
        end
        ST_RF_WAIT: begin
          if (RF_RD_VALID) data_q <= RF_RD_DATA;
        end
        ST_RF_SEND: begin
          if (ser_done) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            cnt_q  <= cnt_q - CNT_ONE;
          end
        end
        ST_GET_OPA, ST_GET_OPB: begin
          if (RX_DATA_VALID) begin
            data_q   <= RX_DATA_IN;
            op_wr_q  <= 1'b1;
            op_sel_q <= (state == ST_GET_OPB);
          end
        end
        ST_GET_FUNC: begin
          if (RX_DATA_VALID) func_q <= RX_DATA_IN[ALU_FUNC_WIDTH-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  sys_ctrl_tx_serializer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESULT_BYTES(RESULT_BYTES)
  ) u_tx_ser (
    .clk     (CLK),
    .rst     (RST),
    .start   (ser_start),
    .word    (ser_word),
    .last_idx(ser_last),
    .tx_full (TX_FULL),
    .tx_data (TX_DATA),
    .tx_wr   (TX_WR),
    .done    (ser_done)
  );

endmodule
